// File: rtl/viterbi_symbol_packer.sv
// Packs per-advance Viterbi decisions into OUT_LEN-symbol words tagged with peak energy, behind a small FIFO.
// Optional bad-symbol counter enabled by defining VITERBI_PACKER_SYM_CHECK_EN.
module viterbi_symbol_packer #(
  parameter int B_LEN      = 2,
  parameter int OUT_LEN    = 16,
  parameter int E_WIDTH    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sym_valid,
  input  logic [B_LEN-1:0][1:0]           final_symbols,
  input  logic [E_WIDTH-1:0]              global_static_energy,
  input  logic [E_WIDTH-1:0]              energy_thresh,
  input  logic                            flush,
  input  logic                            clear_ovf,
  output logic [OUT_LEN-1:0][1:0]         out_symbols,
  output logic [E_WIDTH-1:0]              out_max_energy,
  output logic                            out_hi_energy,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            overflow,
`ifdef VITERBI_PACKER_SYM_CHECK_EN
  output logic [7:0]                      bad_sym_cnt,
`endif
  output logic [$clog2(FIFO_DEPTH):0]     fill_level
);

  localparam int CHUNKS = OUT_LEN / B_LEN;
  localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);

  // Word assembly: symbols are carried as raw 2-bit two's-complement codes.
  logic [KW-1:0]            r_k;
  logic [OUT_LEN-1:0][1:0]  r_word;
  logic [OUT_LEN-1:0][1:0]  w_word;
  logic [E_WIDTH-1:0]       r_peak;
  logic [E_WIDTH-1:0]       w_peak;
  logic                     w_last;
  logic                     w_push;
  logic                     w_hi;

  // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_word = r_word;
    w_peak = r_peak;
    if (sym_valid) begin
      for (int ii = 0; ii < B_LEN; ii++) begin
        w_word[int'(r_k) * B_LEN + ii] = final_symbols[ii];
      end
      if (global_static_energy > r_peak) begin
        w_peak = global_static_energy;
      end
    end
  end

  assign w_last = (r_k == KW'(CHUNKS - 1));
  assign w_push = (sym_valid && w_last) || (flush && ((r_k != '0) || sym_valid));
  assign w_hi   = (w_peak > energy_thresh);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k    <= '0;
      r_word <= '0;
      r_peak <= '0;
    end else if (w_push) begin
      r_k    <= '0;
      r_word <= '0;
      r_peak <= '0;
    end else if (sym_valid) begin
      r_k    <= r_k + KW'(1);
      r_word <= w_word;
      r_peak <= w_peak;
    end
  end

  // Output FIFO with an extra pointer bit separating full from empty.
  logic [OUT_LEN-1:0][1:0]  r_mem_sym  [FIFO_DEPTH];
  logic [E_WIDTH-1:0]       r_mem_peak [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    r_mem_hi;
  logic [AW:0]              r_wr_ptr;
  logic [AW:0]              r_rd_ptr;
  logic                     r_overflow;
  logic                     w_empty;
  logic                     w_full;
  logic                     w_pop;
  logic                     w_wr_en;
  logic                     w_drop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && out_ready;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  // NOTE: storage is not reset; the head outputs are gated by out_valid so stale contents never leak out.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_sym[r_wr_ptr[AW-1:0]]  <= w_word;
      r_mem_peak[r_wr_ptr[AW-1:0]] <= w_peak;
      r_mem_hi[r_wr_ptr[AW-1:0]]   <= w_hi;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
      // A drop in the same cycle as clear_ovf keeps the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign out_valid      = !w_empty;
  assign out_symbols    = out_valid ? r_mem_sym[r_rd_ptr[AW-1:0]]  : '0;
  assign out_max_energy = out_valid ? r_mem_peak[r_rd_ptr[AW-1:0]] : '0;
  assign out_hi_energy  = out_valid && r_mem_hi[r_rd_ptr[AW-1:0]];
  assign overflow       = r_overflow;
  assign fill_level     = r_wr_ptr - r_rd_ptr;

`ifdef VITERBI_PACKER_SYM_CHECK_EN
  // Counts advances carrying the illegal -2 code; the symbol itself is still packed.
  logic       w_bad;
  logic [7:0] r_bad_cnt;

  always_comb begin
    w_bad = 1'b0;
    for (int ii = 0; ii < B_LEN; ii++) begin
      if (final_symbols[ii] == 2'b10) begin
        w_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bad_cnt <= '0;
    end else if (sym_valid && w_bad && (r_bad_cnt != 8'hFF)) begin
      r_bad_cnt <= r_bad_cnt + 8'd1;
    end
  end

  assign bad_sym_cnt = r_bad_cnt;
`endif

endmodule

// File: tb/tb_viterbi_symbol_packer.sv
// Scoreboard bench for viterbi_symbol_packer (OUT_LEN=8, B_LEN=2, FIFO_DEPTH=4).
module tb_viterbi_symbol_packer;

  localparam int OL = 8;
  localparam int BL = 2;
  localparam int EW = 16;
  localparam int FD = 4;

  logic                 clk;
  logic                 rst;
  logic                 sym_valid;
  logic [BL-1:0][1:0]   final_symbols;
  logic [EW-1:0]        global_static_energy;
  logic [EW-1:0]        energy_thresh;
  logic                 flush;
  logic                 clear_ovf;
  logic [OL-1:0][1:0]   out_symbols;
  logic [EW-1:0]        out_max_energy;
  logic                 out_hi_energy;
  logic                 out_valid;
  logic                 out_ready;
  logic                 overflow;
  logic [$clog2(FD):0]  fill_level;
`ifdef VITERBI_PACKER_SYM_CHECK_EN
  logic [7:0]           bad_sym_cnt;
`endif

  viterbi_symbol_packer #(.B_LEN(BL), .OUT_LEN(OL), .E_WIDTH(EW), .FIFO_DEPTH(FD)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .sym_valid            (sym_valid),
    .final_symbols        (final_symbols),
    .global_static_energy (global_static_energy),
    .energy_thresh        (energy_thresh),
    .flush                (flush),
    .clear_ovf            (clear_ovf),
    .out_symbols          (out_symbols),
    .out_max_energy       (out_max_energy),
    .out_hi_energy        (out_hi_energy),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .overflow             (overflow),
`ifdef VITERBI_PACKER_SYM_CHECK_EN
    .bad_sym_cnt          (bad_sym_cnt),
`endif
    .fill_level           (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sym;
    logic [15:0] pk;
    logic        hi;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [15:0] head_snap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Element 0 sits in the least significant bits of the packed word.
  function automatic logic [15:0] mk(input int s0, input int s1, input int s2, input int s3,
                                     input int s4, input int s5, input int s6, input int s7);
    return {s7[1:0], s6[1:0], s5[1:0], s4[1:0], s3[1:0], s2[1:0], s1[1:0], s0[1:0]};
  endfunction

  task automatic expect_word(input logic [15:0] sym, input int pk, input bit hi);
    exp_t e;
    e.sym = sym;
    e.pk  = pk[15:0];
    e.hi  = hi;
    sb.push_back(e);
  endtask

  // Called at posedge+1; drives one advance and returns at the next posedge+1.
  task automatic chunk(input int a, input int b, input int e, input bit fl);
    sym_valid            = 1'b1;
    final_symbols[0]     = a[1:0];
    final_symbols[1]     = b[1:0];
    global_static_energy = e[15:0];
    flush                = fl;
    @(posedge clk);
    #1;
    sym_valid            = 1'b0;
    flush                = 1'b0;
    final_symbols        = '0;
    global_static_energy = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  // Full word of {1,-1} chunks; peak is e. Optionally pulses out_ready with the last chunk.
  task automatic word_same(input int e, input bit hi, input bit pushed, input bit ready_on_last);
    if (pushed) expect_word(mk(1, -1, 1, -1, 1, -1, 1, -1), e, hi);
    chunk(1, -1, e, 1'b0);
    chunk(1, -1, 0, 1'b0);
    chunk(1, -1, 0, 1'b0);
    if (ready_on_last) out_ready = 1'b1;
    chunk(1, -1, 0, 1'b0);
    if (ready_on_last) out_ready = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 100 && !(fill_level == 0 && sb.size() == 0); i++) begin
      @(posedge clk);
      #1;
    end
    check({name, "_fill"}, fill_level, 0);
    check({name, "_sb"}, sb.size(), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected none", out_symbols);
      end else begin
        mon_e = sb.pop_front();
        check("word_sym", out_symbols, mon_e.sym);
        check("word_max", out_max_energy, mon_e.pk);
        check("word_hi", out_hi_energy, mon_e.hi);
      end
    end
  end

  initial begin
    rst                  = 1'b0;
    sym_valid            = 1'b0;
    final_symbols        = '0;
    global_static_energy = '0;
    energy_thresh        = 16'd8;
    flush                = 1'b0;
    clear_ovf            = 1'b0;
    out_ready            = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_sym", out_symbols, 0);
    check("rst_max", out_max_energy, 0);
    check("rst_hi", out_hi_energy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_fill", fill_level, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fill one word.
    out_ready = 1'b1;
    expect_word(mk(1, -1, 0, 1, 1, 1, -1, 0), 9, 1'b1);
    chunk(1, -1, 5, 1'b0);
    chunk(0, 1, 9, 1'b0);
    chunk(1, 1, 3, 1'b0);
    check("fill_not_yet_valid", out_valid, 0);
    chunk(-1, 0, 7, 1'b0);
    check("fill_valid_next_cycle", out_valid, 1);
    wait_drain("fill");

    // Flush a partial word; the next word restarts at position 0 (peak == thresh -> not hi).
    expect_word(mk(1, 1, -1, -1, 0, 0, 0, 0), 4, 1'b0);
    chunk(1, 1, 2, 1'b0);
    chunk(-1, -1, 4, 1'b0);
    do_flush();
    expect_word(mk(1, 0, 0, 0, 0, 0, 0, -1), 8, 1'b0);
    chunk(1, 0, 1, 1'b0);
    chunk(0, 0, 0, 1'b0);
    chunk(0, 0, 0, 1'b0);
    chunk(0, -1, 8, 1'b0);
    // Flush together with sym_valid at k=0 includes that chunk.
    expect_word(mk(-1, 1, 0, 0, 0, 0, 0, 0), 20, 1'b1);
    chunk(-1, 1, 20, 1'b1);
    wait_drain("flush");
    // Flush with nothing pending does nothing.
    do_flush();
    @(posedge clk);
    #1;
    check("empty_flush_valid", out_valid, 0);
    check("empty_flush_fill", fill_level, 0);

    // Backpressure: four words fill the FIFO, the fifth is dropped.
    out_ready = 1'b0;
    word_same(10, 1'b1, 1'b1, 1'b0);
    word_same(3, 1'b0, 1'b1, 1'b0);
    word_same(12, 1'b1, 1'b1, 1'b0);
    word_same(1, 1'b0, 1'b1, 1'b0);
    check("bp_fill4", fill_level, 4);
    check("bp_head_max", out_max_energy, 10);
    head_snap = out_symbols;
    word_same(99, 1'b1, 1'b0, 1'b0);
    check("bp_ovf_set", overflow, 1);
    check("bp_fill_still4", fill_level, 4);
    check("bp_head_stable_sym", out_symbols, head_snap);
    check("bp_head_stable_max", out_max_energy, 10);
    clear_ovf = 1'b1;
    @(posedge clk);
    #1 clear_ovf = 1'b0;
    check("bp_ovf_clear", overflow, 0);
    wait_drain("bp");

    // Full FIFO with a pop in the same cycle as the fifth push.
    out_ready = 1'b0;
    word_same(20, 1'b1, 1'b1, 1'b0);
    word_same(21, 1'b1, 1'b1, 1'b0);
    word_same(22, 1'b1, 1'b1, 1'b0);
    word_same(23, 1'b1, 1'b1, 1'b0);
    word_same(24, 1'b1, 1'b1, 1'b1);
    check("fullpop_fill", fill_level, 4);
    check("fullpop_ovf", overflow, 0);
    check("fullpop_head_max", out_max_energy, 21);
    wait_drain("fullpop");

    // Reset mid-word with three words queued.
    out_ready = 1'b0;
    word_same(30, 1'b1, 1'b1, 1'b0);
    word_same(31, 1'b1, 1'b1, 1'b0);
    word_same(32, 1'b1, 1'b1, 1'b0);
    chunk(1, 1, 40, 1'b0);
    chunk(1, 1, 41, 1'b0);
    check("pre_rst_fill", fill_level, 3);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_fill", fill_level, 0);
    check("mid_rst_sym", out_symbols, 0);
    check("mid_rst_max", out_max_energy, 0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    expect_word(mk(0, 1, 1, 0, -1, -1, 1, -1), 11, 1'b1);
    chunk(0, 1, 6, 1'b0);
    chunk(1, 0, 2, 1'b0);
    chunk(-1, -1, 11, 1'b0);
    chunk(1, -1, 4, 1'b0);
    wait_drain("post_rst");

`ifdef VITERBI_PACKER_SYM_CHECK_EN
    out_ready = 1'b1;
    expect_word(mk(-2, 1, 0, 0, 0, 0, 0, 0), 0, 1'b0);
    chunk(-2, 1, 0, 1'b1);
    check("bad_cnt_1", bad_sym_cnt, 1);
    for (int i = 0; i < 299; i++) begin
      if (i % 4 == 3) expect_word(mk(-2, 1, -2, 1, -2, 1, -2, 1), 0, 1'b0);
      chunk(-2, 1, 0, 1'b0);
    end
    expect_word(mk(-2, 1, -2, 1, -2, 1, 0, 0), 0, 1'b0);
    do_flush();
    check("bad_cnt_sat", bad_sym_cnt, 255);
    wait_drain("bad_sym");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
